// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared definitions for the AHB-Lite SRAM slave: bus widths, HTRANS/HSIZE/HRESP
// codes, slave FSM state encoding and the byte-lane decode helper.
// Optional build macro used by the top level: AHB_SLV_WR_PROTECT_EN.
package ahb_lite_sram_slave_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

  // Little-endian byte lanes touched by a legal access of the given size.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised storage for the SRAM slave: synchronous write with four byte
// enables and a combinational read port so the completing data cycle can
// present the addressed word directly. Contents are not reset.
module ahb_slv_mem #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_array [DEPTH];

  // Byte-lane masked write on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_array[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and a two-cycle ERROR
// response for out-of-range, oversize or misaligned accesses.
// Build macro AHB_SLV_WR_PROTECT_EN adds RO_WORDS: writes to the lowest
// RO_WORDS words are answered with ERROR and leave memory unchanged.
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = AHB_DATA_WIDTH,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 1
`ifdef AHB_SLV_WR_PROTECT_EN
  , parameter int RO_WORDS = 16
`endif
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic pending_reg, pending_next;
  logic write_reg;
  logic [2:0] size_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [1:0] lo_reg;
  logic [DATA_WIDTH-1:0] hrdata_reg;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] offset;
  logic accept, addr_err, completing, mem_we;
  logic [3:0] mem_be;
  logic unused_inputs;

  // Burst type and the SEQ/NONSEQ distinction do not affect a single-beat slave.
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
  assign offset = HADDR - BASE_ADDR;
  assign accept = HSEL && HTRANS[1] && HREADY;

  // Classify the address-phase request as legal or ERROR-worthy.
  always_comb begin
    addr_err = 1'b0;
    if (offset >= MEM_BYTES) addr_err = 1'b1;
    if (HSIZE > HSIZE_WORD) addr_err = 1'b1;
    if (HSIZE == HSIZE_HALF && HADDR[0]) addr_err = 1'b1;
    if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) addr_err = 1'b1;
`ifdef AHB_SLV_WR_PROTECT_EN
    if (HWRITE && (int'(offset[IDX_W+1:2]) < RO_WORDS)) addr_err = 1'b1;
`endif
  end

  // Next-state logic: a pending legal transfer completes in IDLE with HREADY high.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        state_next   = ST_IDLE;
        pending_next = 1'b0;
        if (accept) begin
          if (addr_err) begin
            state_next = ST_ERR1;
          end else begin
            pending_next = 1'b1;
            if (WAIT_STATES > 0) begin
              state_next = ST_WAIT;
              cnt_next   = WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_IDLE;
        else cnt_next = cnt_reg - 4'd1;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  assign HREADY     = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign HRESP      = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign completing = (state_reg == ST_IDLE) && pending_reg;
  assign mem_we     = completing && write_reg;
  assign mem_be     = lane_enables(size_reg, lo_reg);
  assign HRDATA     = (completing && !write_reg) ? mem_rdata : hrdata_reg;

  // State, wait counter, captured address phase and held read data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      pending_reg <= 1'b0;
      write_reg   <= 1'b0;
      size_reg    <= 3'd0;
      idx_reg     <= '0;
      lo_reg      <= 2'd0;
      hrdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      if (completing && !write_reg) hrdata_reg <= mem_rdata;
      if (accept) begin
        write_reg <= HWRITE;
        size_reg  <= HSIZE;
        idx_reg   <= offset[IDX_W+1:2];
        lo_reg    <= HADDR[1:0];
      end
    end
  end

  ahb_slv_mem #(
    .DEPTH(MEM_DEPTH),
    .IDX_W(IDX_W)
  ) u_mem (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (mem_be),
    .addr (idx_reg),
    .wdata(HWDATA),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with one wait state and
// one with zero wait states share the bus; each is selected by its own HSEL.
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel_a, hsel_b;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        hready_a, hresp_a, hready_b, hresp_b;
  logic [31:0] hrdata_a, hrdata_b;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(1)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_a), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(hready_a), .HRESP(hresp_a), .HRDATA(hrdata_a)
  );

  ahb_lite_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(hready_b), .HRESP(hresp_b), .HRDATA(hrdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; drives one address phase, then follows the data
  // phase until HREADY is seen high (bounded), returning at that falling edge
  // so a following call starts its address phase in the completion cycle.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic first_resp, output logic last_resp, output int cycles);
    logic rdy;
    hsel_a = !b;
    hsel_b = b;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    @(posedge HCLK);
    #1;
    hsel_a = 1'b0;
    hsel_b = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wdata;
    cycles = 0;
    rdy = 1'b0;
    first_resp = 1'b0;
    last_resp = 1'b0;
    rdata = '0;
    while (!rdy && cycles < 20) begin
      @(negedge HCLK);
      cycles++;
      rdy       = b ? hready_b : hready_a;
      last_resp = b ? hresp_b : hresp_a;
      rdata     = b ? hrdata_b : hrdata_a;
      if (cycles == 1) first_resp = last_resp;
      if (!rdy) @(posedge HCLK);
    end
    chk("hready_timeout", {31'd0, rdy}, 32'd1);
    $display("xfer dut=%0d wr=%0b addr=%h size=%0d wdata=%h rdata=%h resp=%0b/%0b cycles=%0d",
             b, wr, addr, size, wdata, rdata, first_resp, last_resp, cycles);
  endtask

  task automatic wr_chk(input string tag, input bit b, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int exp_cycles, input logic exp_resp);
    logic [31:0] rd;
    logic r0, r1;
    int n;
    xfer(b, 1'b1, addr, size, wdata, rd, r0, r1, n);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_resp_first"}, {31'd0, r0}, {31'd0, exp_resp});
    chk({tag, "_resp_last"}, {31'd0, r1}, {31'd0, exp_resp});
  endtask

  task automatic rd_chk(input string tag, input bit b, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] exp_data, input int exp_cycles, input logic exp_resp);
    logic [31:0] rd;
    logic r0, r1;
    int n;
    xfer(b, 1'b0, addr, size, 32'h0, rd, r0, r1, n);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_resp_first"}, {31'd0, r0}, {31'd0, exp_resp});
    chk({tag, "_resp_last"}, {31'd0, r1}, {31'd0, exp_resp});
    chk({tag, "_data"}, rd, exp_data);
  endtask

  initial begin
    HRESETn = 1'b0;
    hsel_a = 1'b0;
    hsel_b = 1'b0;
    HADDR = '0;
    HWRITE = 1'b0;
    HSIZE = 3'b010;
    HBURST = 3'b000;
    HTRANS = 2'b00;
    HWDATA = '0;
    #1;
    chk("rst_hready", {31'd0, hready_a}, 32'd1);
    chk("rst_hresp", {31'd0, hresp_a}, 32'd0);
    chk("rst_hrdata", hrdata_a, 32'd0);
    chk("rst_hready_b", {31'd0, hready_b}, 32'd1);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // One wait state: every OKAY data phase is two cycles.
    wr_chk("wr_word_10", 1'b0, 32'h10, 3'b010, 32'hDEAD_BEEF, 2, 1'b0);
    rd_chk("rd_word_10", 1'b0, 32'h10, 3'b010, 32'hDEAD_BEEF, 2, 1'b0);

    // Byte lane 3 only; the other lanes carry junk that must be ignored.
    wr_chk("wr_word_1122", 1'b0, 32'h10, 3'b010, 32'h1122_3344, 2, 1'b0);
    wr_chk("wr_byte_13", 1'b0, 32'h13, 3'b000, 32'h5AFF_FFFF, 2, 1'b0);
    rd_chk("rd_after_byte", 1'b0, 32'h10, 3'b010, 32'h5A22_3344, 2, 1'b0);

    // Out of range: two-cycle ERROR, read data held from the last read.
    rd_chk("rd_oor_400", 1'b0, 32'h400, 3'b010, 32'h5A22_3344, 2, 1'b1);

    // Misaligned word write must not touch word 0.
    wr_chk("wr_word_00", 1'b0, 32'h00, 3'b010, 32'h0000_CAFE, 2, 1'b0);
    wr_chk("wr_misalign_02", 1'b0, 32'h02, 3'b010, 32'hFFFF_FFFF, 2, 1'b1);
    rd_chk("rd_word_00", 1'b0, 32'h00, 3'b010, 32'h0000_CAFE, 2, 1'b0);

    // Upper halfword, then illegal half and oversize accesses.
    wr_chk("wr_half_12", 1'b0, 32'h12, 3'b001, 32'hBEEF_FFFF, 2, 1'b0);
    rd_chk("rd_after_half", 1'b0, 32'h10, 3'b010, 32'hBEEF_3344, 2, 1'b0);
    wr_chk("wr_half_11", 1'b0, 32'h11, 3'b001, 32'h0000_0000, 2, 1'b1);
    rd_chk("rd_size_011", 1'b0, 32'h10, 3'b011, 32'hBEEF_3344, 2, 1'b1);
    rd_chk("rd_byte_12", 1'b0, 32'h12, 3'b000, 32'hBEEF_3344, 2, 1'b0);

    // Last word in range.
    wr_chk("wr_last_3fc", 1'b0, 32'h3FC, 3'b010, 32'h600D_F00D, 2, 1'b0);
    rd_chk("rd_last_3fc", 1'b0, 32'h3FC, 3'b010, 32'h600D_F00D, 2, 1'b0);

    // Zero wait states: back-to-back with HREADY never low.
    wr_chk("b_wr_0", 1'b1, 32'h0, 3'b010, 32'd1, 1, 1'b0);
    wr_chk("b_wr_4", 1'b1, 32'h4, 3'b010, 32'd2, 1, 1'b0);
    rd_chk("b_rd_0", 1'b1, 32'h0, 3'b010, 32'd1, 1, 1'b0);
    rd_chk("b_rd_4", 1'b1, 32'h4, 3'b010, 32'd2, 1, 1'b0);
    rd_chk("b_rd_oor", 1'b1, 32'h400, 3'b010, 32'd2, 2, 1'b1);

    // Reset while a write sits in its wait state.
    wr_chk("wr_word_20", 1'b0, 32'h20, 3'b010, 32'h1234_5678, 2, 1'b0);
    hsel_a = 1'b1;
    HTRANS = 2'b10;
    HADDR  = 32'h20;
    HWRITE = 1'b1;
    HSIZE  = 3'b010;
    @(posedge HCLK);
    #1;
    hsel_a = 1'b0;
    HTRANS = 2'b00;
    HWDATA = 32'hFFFF_FFFF;
    #1;
    chk("wait_hready_low", {31'd0, hready_a}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst_hready", {31'd0, hready_a}, 32'd1);
    chk("midrst_hresp", {31'd0, hresp_a}, 32'd0);
    chk("midrst_hrdata", hrdata_a, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("rd_after_rst", 1'b0, 32'h20, 3'b010, 32'h1234_5678, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
